decoder_share_sched: RTL and testbench
======================================

DECODER_SHARE_SCHED -- requirements
Module: decoder_share_sched

Interface
REQ-001 SHALL have parameter DEC_LAT, default 2, range 0..15: decoder pipeline latency in cycles.
REQ-002 SHALL have port wb_clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  4  per-requester request strobe.
REQ-005 SHALL have port req_code  input  28  requester i 7-bit code at bits [7i+6:7i].
REQ-006 SHALL have port req_ready  output  4  one-hot accept, combinational from state, pointer and req_valid.
REQ-007 SHALL have port dec_in  output  7  registered code driven to the shared decoder.
REQ-008 SHALL have port dec_out  input  8  decoder result.
REQ-009 SHALL have port resp_valid  output  1  result available.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port resp_id  output  2  index of the requester owning the result.
REQ-012 SHALL have port resp_data  output  8  captured decoder result.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP, with a 4-bit counter cnt and a 2-bit last-grant pointer lg.
REQ-015 IDLE: if any req_valid is high, SHALL drive req_ready high for exactly one requester g, chosen as the first set req_valid scanning lg+1, lg+2, lg+3, lg (mod 4).
REQ-016 Accept, defined as req_valid[g] and req_ready[g] in cycle c, SHALL, at the end of c: latch code_q from req_code slice g, set id_q to g, set lg to g, load cnt with DEC_LAT, and enter WAIT.
REQ-017 dec_in SHALL equal code_q, held stable from cycle c+1 until the next accept.
REQ-018 WAIT: if cnt is nonzero, cnt SHALL decrement; if cnt is 0, resp_data SHALL capture dec_out and the FSM SHALL enter RESP, giving a capture at the end of cycle c+1+DEC_LAT.
REQ-019 RESP: resp_valid SHALL be 1 first in cycle c+2+DEC_LAT, and resp_id SHALL equal id_q.
REQ-020 resp_valid, resp_id and resp_data SHALL hold stable until resp_ready is high; on that cycle the FSM SHALL return to IDLE.
REQ-021 req_ready SHALL be all-zero in WAIT and RESP, and in IDLE when no req_valid is set.
REQ-022 A requester dropping req_valid before accept SHALL leave no effect; req_code SHALL be sampled only on the accept cycle.
REQ-023 Minimum transaction period SHALL be DEC_LAT+3 cycles, with the next accept no earlier than the cycle after the resp handshake.
REQ-024 DEC_LAT=0 SHALL be legal: one WAIT cycle, with resp_valid in cycle c+2.
REQ-025 With all 4 requesters continuously valid, grants SHALL rotate 0,1,2,3,0 with no starvation.
REQ-026 resp_ready high outside RESP SHALL be ignored.

Reset
REQ-027 wb_rst_i high at a rising edge SHALL force state IDLE, lg=3, cnt=0, code_q=0, id_q=0, resp_data=0.
REQ-028 During and after reset, outputs SHALL be req_ready=0 while reset is high, dec_in=0, resp_valid=0, resp_id=0, resp_data=0, busy=0.
REQ-029 Reset asserted during WAIT or RESP SHALL discard the in-flight transaction without producing a response.
REQ-030 The first grant after reset SHALL go to the lowest-index valid requester, starting the scan at requester 0.

Verification
REQ-031 Single request, DEC_LAT=2: req_valid=4'b0100, code 7'b1110000, decoder model returning {1'b0,code} -> req_ready=4'b0100 in cycle c, dec_in=7'h70 from c+1, resp_valid in c+4 with resp_id=2 and resp_data=8'h70.
REQ-032 All four requesters held valid with resp_ready tied to 1 -> accepts in order 0,1,2,3,0, spaced exactly 5 cycles apart.
REQ-033 resp_ready held 0 for 10 cycles in RESP -> resp_valid, resp_data and resp_id stable, req_ready=0 and busy=1 throughout, then IDLE one cycle after resp_ready=1.
REQ-034 wb_rst_i pulsed in WAIT -> no resp_valid, all outputs 0, and the next request from requester 3 alone is granted normally.
REQ-035 DEC_LAT=0 with req_valid=4'b0001 -> resp_valid in cycle c+2 carrying dec_out sampled at the end of c+1.
REQ-036 Requester 1 pulses req_valid during WAIT and drops it before IDLE -> it is never granted, and resp_id reflects only the accepted requesters.

Source files
------------

// File: rtl/decoder_share_sched.sv
// rtl/decoder_share_sched.sv - round-robin sharing of one pipelined decoder among four requesters
//
// Four requesters compete for a single shared decoder. One request is in
// flight at a time: a round-robin grant accepts a code, the code is driven
// to the decoder, the result is captured after DEC_LAT cycles, and it is
// held on the response port until the consumer takes it.
//
// Ports:
//   wb_clk_i    in   1   clock, rising edge
//   wb_rst_i    in   1   synchronous active-high reset
//   req_valid   in   4   per-requester request strobe
//   req_code    in  28   requester i code at [7i+6:7i]
//   req_ready   out  4   one-hot accept (IDLE only)
//   dec_in      out  7   registered code to the shared decoder
//   dec_out     in   8   decoder result
//   resp_valid  out  1   result available
//   resp_ready  in   1   consumer accepts result
//   resp_id     out  2   requester owning the result
//   resp_data   out  8   captured decoder result
//   busy        out  1   high whenever not IDLE
module decoder_share_sched #(
  parameter int unsigned DEC_LAT = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [3:0]  req_valid,
  input  logic [27:0] req_code,
  output logic [3:0]  req_ready,
  output logic [6:0]  dec_in,
  input  logic [7:0]  dec_out,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [1:0]  resp_id,
  output logic [7:0]  resp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT = 4'(DEC_LAT);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  lg_q;
  logic [1:0]  id_q;
  logic [6:0]  code_q;
  logic [7:0]  data_q;

  logic        grant_any;
  logic [1:0]  grant_idx;
  logic [1:0]  scan_idx;
  logic [6:0]  codes [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      codes[i] = req_code[7*i +: 7];
    end
  end

  // Scan lg+4 (== lg) down to lg+1; the last hit wins, so lg+1 has the
  // highest priority and the previous winner the lowest.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = lg_q;
    scan_idx  = lg_q;
    for (int k = 4; k >= 1; k--) begin
      scan_idx = lg_q + 2'(k);
      if (req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Reset gates the grant so nothing is offered while reset is held.
  always_comb begin
    req_ready = 4'b0000;
    if (state_q == IDLE && !wb_rst_i && grant_any) begin
      req_ready = 4'b0001 << grant_idx;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lg_q    <= 2'd3;
      id_q    <= 2'd0;
      code_q  <= 7'd0;
      data_q  <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            code_q  <= codes[grant_idx];
            id_q    <= grant_idx;
            lg_q    <= grant_idx;
            cnt_q   <= LAT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // cnt counts the remaining pipeline cycles; at zero dec_out
          // reflects the code that has been on dec_in since acceptance.
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            data_q  <= dec_out;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dec_in     = code_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_data  = data_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_share_sched.sv
// tb/tb_decoder_share_sched.sv - self-checking bench for decoder_share_sched (DEC_LAT=2 and DEC_LAT=0)
module tb_decoder_share_sched;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic [27:0] req_code;
  logic        resp_ready;

  logic [3:0]  rdy   [2];
  logic [6:0]  din   [2];
  logic [7:0]  dout  [2];
  logic        rv    [2];
  logic [1:0]  rid   [2];
  logic [7:0]  rdata [2];
  logic        bsy   [2];

  logic [7:0]  pipe_a [2];

  int n_chk;
  int n_pass;
  int cyc;

  // transaction-level reference model, one per instance
  bit          m_active [2];
  int          m_acc    [2];
  logic [1:0]  m_id     [2];
  logic [7:0]  m_data   [2];
  logic [6:0]  m_code   [2];
  int          m_lg     [2];

  function automatic logic [7:0] dec_fn(input logic [6:0] x);
    return {1'b0, x} ^ {x[3:0], 4'b0000};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic string tagk(input string s, input int k);
    return $sformatf("%s_lat%0d", s, lat_of(k));
  endfunction

  // shared decoder models: a true 2-stage pipeline and a combinational one
  always @(posedge clk) begin
    pipe_a[0] <= dec_fn(din[0]);
    pipe_a[1] <= pipe_a[0];
  end
  assign dout[0] = pipe_a[1];
  assign dout[1] = dec_fn(din[1]);

  decoder_share_sched #(.DEC_LAT(2)) u_dut_a (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ready  (rdy[0]),
    .dec_in     (din[0]),
    .dec_out    (dout[0]),
    .resp_valid (rv[0]),
    .resp_ready (resp_ready),
    .resp_id    (rid[0]),
    .resp_data  (rdata[0]),
    .busy       (bsy[0])
  );

  decoder_share_sched #(.DEC_LAT(0)) u_dut_b (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ready  (rdy[1]),
    .dec_in     (din[1]),
    .dec_out    (dout[1]),
    .resp_valid (rv[1]),
    .resp_ready (resp_ready),
    .resp_id    (rid[1]),
    .resp_data  (rdata[1]),
    .busy       (bsy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0;
      m_acc[k]    = 0;
      m_id[k]     = 2'd0;
      m_data[k]   = 8'd0;
      m_code[k]   = 7'd0;
      m_lg[k]     = 3;
    end
  endtask

  // Inputs are already applied; compare at the falling edge, then advance
  // the model across the coming rising edge.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int         g;
      logic [3:0] exp_rdy;
      bit         exp_rv;
      g = -1;
      if (!m_active[k]) begin
        for (int j = 1; j <= 4; j++) begin
          int idx;
          idx = (m_lg[k] + j) % 4;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      exp_rdy = (rst || g < 0) ? 4'b0000 : 4'(1 << g);
      exp_rv  = m_active[k] && (cyc >= m_acc[k] + 2 + lat_of(k));
      check(tagk("req_ready", k), 32'(rdy[k]), 32'(exp_rdy));
      check(tagk("resp_valid", k), 32'(rv[k]), 32'(exp_rv));
      check(tagk("busy", k), 32'(bsy[k]), 32'(m_active[k]));
      check(tagk("dec_in", k), 32'(din[k]), 32'(m_code[k]));
      if (exp_rv) begin
        check(tagk("resp_id", k), 32'(rid[k]), 32'(m_id[k]));
        check(tagk("resp_data", k), 32'(rdata[k]), 32'(m_data[k]));
      end
      if (rst) begin
        m_active[k] = 1'b0;
        m_lg[k]     = 3;
        m_code[k]   = 7'd0;
        m_id[k]     = 2'd0;
        m_data[k]   = 8'd0;
      end else if (exp_rdy != 4'b0000) begin
        m_active[k] = 1'b1;
        m_acc[k]    = cyc;
        m_id[k]     = 2'(g);
        m_lg[k]     = g;
        m_code[k]   = req_code[7*g +: 7];
        m_data[k]   = dec_fn(m_code[k]);
      end else if (exp_rv && resp_ready) begin
        m_active[k] = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    cyc        = 0;
    rst        = 1'b1;
    req_valid  = 4'b0000;
    req_code   = 28'd0;
    resp_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      check(tagk("rst_resp_data", k), 32'(rdata[k]), 32'h0);
      check(tagk("rst_resp_id", k), 32'(rid[k]), 32'h0);
      check(tagk("rst_dec_in", k), 32'(din[k]), 32'h0);
    end
    rst = 1'b0;

    // single request from requester 2, code 7'h70
    req_code[20:14] = 7'h70;
    req_valid = 4'b0100;
    step();
    req_valid = 4'b0000;
    req_code  = 28'h0;
    repeat (3) step();
    resp_ready = 1'b1;
    repeat (3) step();

    // all four continuously valid, consumer always ready
    req_valid = 4'b1111;
    for (int i = 0; i < 24; i++) begin
      req_code = 28'($urandom);
      step();
    end
    req_valid = 4'b0000;
    repeat (6) step();

    // long back-pressure in RESP
    req_code  = 28'($urandom);
    req_valid = 4'b0001;
    resp_ready = 1'b0;
    step();
    req_valid = 4'b0000;
    repeat (14) step();
    resp_ready = 1'b1;
    repeat (3) step();

    // reset pulse while in WAIT, then requester 3 alone
    resp_ready = 1'b0;
    req_code   = 28'($urandom);
    req_valid  = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < 2; k++) begin
      check(tagk("post_rst_resp_data", k), 32'(rdata[k]), 32'h0);
      check(tagk("post_rst_busy", k), 32'(bsy[k]), 32'h0);
    end
    req_code  = 28'($urandom);
    req_valid = 4'b1000;
    step();
    req_valid = 4'b0000;
    repeat (4) step();
    resp_ready = 1'b1;
    repeat (2) step();

    // requester 1 pulses only while the block is busy
    req_code  = 28'($urandom);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    repeat (6) step();

    // randomized traffic with occasional reset
    for (int i = 0; i < 800; i++) begin
      req_valid  = 4'($urandom);
      req_code   = 28'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 60) == 0);
      step();
    end
    rst = 1'b0;
    req_valid = 4'b0000;
    resp_ready = 1'b1;
    repeat (6) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
